// File: rtl/nios_system_com_ocmem_dp.sv
// rtl/nios_system_com_ocmem_dp.sv - dual-port Avalon-MM on-chip RAM with byte enables and optional zero-scrub
//
// Purpose: DEPTH x DATA_W RAM shared by two Avalon-MM slaves (s1 = Nios data master,
//   s2 = com DMA). Reads are pipelined (READ_LATENCY 1 or 2 enabled cycles) and return
//   readdatavalid. Same-cycle writes to one word merge per lane, and s1 wins any lane that
//   both ports enable. A read that meets a write to the same word returns the old contents.
// Optional feature macro: OCMEM_CLEAR_EN
//   defined   - scrub FSM zeroes the array after reset or on clear_req; busy stalls both ports.
//   undefined - no scrub; busy=0, clear_req ignored; contents retained across reset and
//               preloaded from INIT_FILE by the RAM-macro init flow.
// Ports:
//   clk, reset_n (sync, active-low), clken (0 freezes all state)
//   clear_req (scrub start pulse), busy (scrub in progress)
//   sN_chipselect/read/write/address/byteenable/writedata   request side, N = 1,2
//   sN_readdata/readdatavalid/waitrequest                    response side, N = 1,2
module nios_system_com_ocmem_dp #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 768,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "nios_system_com_ocmemory.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                clear_req,
  output logic                busy,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  // The image name is only meaningful to the RAM-macro init flow.
  localparam int unused_init_bits = $bits(INIT_FILE);

  // Index 0 = s1, index 1 = s2.
  logic [1:0]        csel, rreq, wreq, acc, wr, rd, inr, vout;
  logic [ADDR_W-1:0] addr [2];
  logic [BE_W-1:0]   be   [2];
  logic [DATA_W-1:0] wdat [2];
  logic [DATA_W-1:0] rdat [2];
  logic [DATA_W-1:0] dout [2];
  logic [DATA_W-1:0] mem  [DEPTH];
  logic              waitreq;
  logic              scrub_we;

  assign csel    = {s2_chipselect, s1_chipselect};
  assign rreq    = {s2_read, s1_read};
  assign wreq    = {s2_write, s1_write};
  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0]   = s1_byteenable;
  assign be[1]   = s2_byteenable;
  assign wdat[0] = s1_writedata;
  assign wdat[1] = s2_writedata;

  assign waitreq        = busy | ~clken;
  assign s1_waitrequest = waitreq;
  assign s2_waitrequest = waitreq;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign acc[p]  = csel[p] & (rreq[p] | wreq[p]) & ~waitreq;
    assign wr[p]   = acc[p] & wreq[p];
    // A combined read+write performs only the write.
    assign rd[p]   = acc[p] & rreq[p] & ~wreq[p];
    assign inr[p]  = {1'b0, addr[p]} < DEPTH_L;
    assign rdat[p] = inr[p] ? mem[addr[p]] : '0;

    logic              v1;
    logic [DATA_W-1:0] d1;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else if (clken) begin
        v1 <= rd[p];
        if (rd[p]) d1 <= rdat[p];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic              v2;
      logic [DATA_W-1:0] d2;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else if (clken) begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign vout[p] = v2;
      assign dout[p] = d2;
    end else begin : g_lat1
      assign vout[p] = v1;
      assign dout[p] = d1;
    end
  end

  // A held valid would be seen again on every frozen cycle, so it is only
  // presented while the pipeline is enabled.
  assign s1_readdatavalid = vout[0] & clken;
  assign s2_readdatavalid = vout[1] & clken;
  assign s1_readdata      = dout[0];
  assign s2_readdata      = dout[1];

`ifdef OCMEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (clken) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nx = READY;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      default: begin
        if (clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state == CLEAR);
    scrub_we = (state == CLEAR);
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign busy             = 1'b0;
  assign scrub_we         = 1'b0;
`endif

  // s2 lanes are written first so s1 overrides any lane both ports enable.
  // Ports never write while scrubbing because busy holds waitrequest.
  always_ff @(posedge clk) begin
    if (clken) begin
`ifdef OCMEM_CLEAR_EN
      if (scrub_we) mem[cnt] <= '0;
`endif
      if (wr[1] && inr[1]) begin
        for (int b = 0; b < BE_W; b++)
          if (be[1][b]) mem[addr[1]][8*b +: 8] <= wdat[1][8*b +: 8];
      end
      if (wr[0] && inr[0]) begin
        for (int b = 0; b < BE_W; b++)
          if (be[0][b]) mem[addr[0]][8*b +: 8] <= wdat[0][8*b +: 8];
      end
    end
  end

`ifndef OCMEM_CLEAR_EN
  logic unused_scrub_we;
  assign unused_scrub_we = scrub_we;
`endif

endmodule
